// File: rtl/mc_main_ctrl.sv
// Purpose: multi-cycle main control FSM for the MIPS-subset CPU (fetch/decode/execute/mem/writeback).
// Latency: j/beq 3 cycles, R/addi/slti/sw 4, lw 5, with mem_ready_i held high.
// Backpressure: FETCH, MRD and MWR hold (strobes constant) while mem_ready_i is low.
//
// Ports:
//   clk_i, rst_i         rising-edge clock, asynchronous active-high reset
//   opcode_i             IR[31:26], stable from DECODE onward
//   mem_ready_i          memory completes the current access this cycle
//   PCWrite_o, PCWriteCond_o, PCSource_o    PC update controls
//   IorD_o, MemRead_o, MemWrite_o, IRWrite_o memory / IR controls
//   RegDst_o, MemtoReg_o, RegWrite_o        register file controls
//   ALUSrcA_o, ALUSrcB_o, ALUOp_o           ALU operand / operation selects
//   illegal_o            unsupported opcode seen in DECODE
//   state_o              current state (debug)
module mc_main_ctrl (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output logic       PCWrite_o,
   output logic       PCWriteCond_o,
   output logic       IorD_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic       IRWrite_o,
   output logic       RegDst_o,
   output logic       MemtoReg_o,
   output logic       RegWrite_o,
   output logic       ALUSrcA_o,
   output logic [1:0] ALUSrcB_o,
   output logic [1:0] ALUOp_o,
   output logic [1:0] PCSource_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_J    = 6'd2;
   localparam logic [5:0] OP_BEQ  = 6'd4;
   localparam logic [5:0] OP_ADDI = 6'd8;
   localparam logic [5:0] OP_SLTI = 6'd10;
   localparam logic [5:0] OP_LW   = 6'd35;
   localparam logic [5:0] OP_SW   = 6'd43;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_R_WB      = 4'd4,
      S_EXEC_ADDI = 4'd5,
      S_I_WB      = 4'd6,
      S_MADDR     = 4'd7,
      S_MRD       = 4'd8,
      S_M_WB      = 4'd9,
      S_MWR       = 4'd10,
      S_BRANCH    = 4'd11,
      S_JUMP      = 4'd12,
      S_EXEC_SLTI = 4'd13
   } state_t;

   state_t state;
   state_t state_nxt;

   // Asynchronous reset forces IDLE immediately; since every output decodes
   // to 0 in IDLE, any in-flight write strobe drops the same instant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   assign state_o = state;

   always_comb begin
      state_nxt     = state;
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      RegDst_o      = 1'b0;
      MemtoReg_o    = 1'b0;
      RegWrite_o    = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = 2'b00;
      ALUOp_o       = 2'b00;
      PCSource_o    = 2'b00;
      illegal_o     = 1'b0;

      case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            // PC+4 computed by the ALU every FETCH cycle; IR and PC only
            // latch on the cycle the memory actually returns the word.
            MemRead_o = 1'b1;
            ALUSrcB_o = 2'b01;
            ALUOp_o   = 2'b01;
            IRWrite_o = mem_ready_i;
            PCWrite_o = mem_ready_i;
            state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target precomputed into ALUOut in case this is a beq.
            ALUSrcB_o = 2'b11;
            ALUOp_o   = 2'b01;
            case (opcode_i)
               OP_R:         state_nxt = S_EXEC_R;
               OP_ADDI:      state_nxt = S_EXEC_ADDI;
               OP_SLTI:      state_nxt = S_EXEC_SLTI;
               OP_LW, OP_SW: state_nxt = S_MADDR;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_J:         state_nxt = S_JUMP;
               default: begin
                  state_nxt = S_FETCH;
                  illegal_o = 1'b1;
               end
            endcase
         end
         S_EXEC_R: begin
            ALUSrcA_o = 1'b1;
            state_nxt = S_R_WB;
         end
         S_R_WB: begin
            RegDst_o   = 1'b1;
            RegWrite_o = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_EXEC_ADDI: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            ALUOp_o   = 2'b01;
            state_nxt = S_I_WB;
         end
         S_EXEC_SLTI: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            ALUOp_o   = 2'b10;
            state_nxt = S_I_WB;
         end
         S_I_WB: begin
            RegWrite_o = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MADDR: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            ALUOp_o   = 2'b01;
            state_nxt = (opcode_i == OP_LW) ? S_MRD : S_MWR;
         end
         S_MRD: begin
            MemRead_o = 1'b1;
            IorD_o    = 1'b1;
            state_nxt = mem_ready_i ? S_M_WB : S_MRD;
         end
         S_M_WB: begin
            MemtoReg_o = 1'b1;
            RegWrite_o = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MWR: begin
            MemWrite_o = 1'b1;
            IorD_o     = 1'b1;
            state_nxt  = mem_ready_i ? S_FETCH : S_MWR;
         end
         S_BRANCH: begin
            ALUSrcA_o     = 1'b1;
            ALUOp_o       = 2'b11;
            PCWriteCond_o = 1'b1;
            PCSource_o    = 2'b01;
            state_nxt     = S_FETCH;
         end
         S_JUMP: begin
            PCWrite_o  = 1'b1;
            PCSource_o = 2'b10;
            state_nxt  = S_FETCH;
         end
         default: begin
            // Unused codes 14/15 recover straight to FETCH.
            state_nxt = S_FETCH;
         end
      endcase
   end

endmodule
